cluster_ldst_scheduler: RTL and testbench



---
 rtl/cluster_ldst_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_cluster_ldst_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_ldst_scheduler.sv
// Purpose : global sequencer for vector loads/stores; splits one instruction into
//           per-cluster slices following the cluster/lane element interleave,
//           issues each slice independently and aggregates completions.
// Latency : accept -> cl_valid_o 1 cycle; last accepted done -> resp_valid_o 1 cycle;
//           vl = 0 accept -> resp_valid_o 1 cycle; resp handshake -> req_ready_o 1 cycle.
// Backpr. : one instruction in flight; req_ready_o stays low from accept until the
//           response handshake. Each cluster command is held until its own ready.
// Ports   : clk_i/rst_i (sync, active-high); req_* dispatch request (valid/ready);
//           cl_* per-cluster command (valid/ready), completion pulse and error;
//           resp_* aggregated response (valid/ready) with OR-ed error.
// All outputs are decoded from registers only; no input reaches an output combinationally.
module cluster_ldst_scheduler #(
   parameter int unsigned NrLanes    = 4,
   parameter int unsigned NrClusters = 4,
   parameter int unsigned AddrWidth  = 64,
   parameter int unsigned VlWidth    = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   // Dispatch request
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   input  logic                            req_store_i,
   input  logic [AddrWidth-1:0]            req_addr_i,
   input  logic [VlWidth-1:0]              req_vl_i,
   input  logic [1:0]                      req_vsew_i,
   // Per-cluster command
   output logic [NrClusters-1:0]           cl_valid_o,
   input  logic [NrClusters-1:0]           cl_ready_i,
   output logic [NrClusters-1:0]           cl_store_o,
   output logic [NrClusters*AddrWidth-1:0] cl_addr_o,
   output logic [NrClusters*VlWidth-1:0]   cl_vl_o,
   output logic [NrClusters*2-1:0]         cl_vsew_o,
   // Per-cluster completion
   input  logic [NrClusters-1:0]           cl_done_i,
   input  logic [NrClusters-1:0]           cl_err_i,
   // Aggregated response
   output logic                            resp_valid_o,
   input  logic                            resp_ready_i,
   output logic                            resp_err_o
);

   localparam int unsigned LogLanes = $clog2(NrLanes);
   localparam int unsigned LogGroup = $clog2(NrClusters * NrLanes);
   localparam logic [VlWidth-1:0] GroupMask = VlWidth'(NrClusters * NrLanes - 1);
   localparam logic [VlWidth-1:0] LanesVl   = VlWidth'(NrLanes);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [VlWidth-1:0]   vl;
   } slice_t;

   state_e                  state_q, state_d;
   logic                    req_ready_q;
   slice_t [NrClusters-1:0] slice_q, slice_d;
   logic                    store_q;
   logic [1:0]              vsew_q;
   logic [NrClusters-1:0]   pend_q, pend_d;
   logic [NrClusters-1:0]   issued_q, issued_n;
   logic [NrClusters-1:0]   done_q, done_n;
   logic                    err_q, err_n;

   logic                    req_fire;
   logic [NrClusters-1:0]   cl_valid;
   logic [NrClusters-1:0]   issue_fire;
   logic [NrClusters-1:0]   done_acc;

   logic [VlWidth-1:0]      vl_rem;
   logic [VlWidth-1:0]      vl_rounds;
   logic [VlWidth-1:0]      lane_lo;
   logic [VlWidth-1:0]      tail;

   // ---------------------------------------------------------------------
   // Slice computation. Full rounds of G elements give every cluster
   // NrLanes elements; the remainder r fills clusters in order, NrLanes each.
   // ---------------------------------------------------------------------
   always_comb begin
      vl_rem    = req_vl_i & GroupMask;
      vl_rounds = (req_vl_i >> LogGroup) << LogLanes;
      lane_lo   = '0;
      tail      = '0;
      slice_d   = '0;
      pend_d    = '0;
      for (int unsigned c = 0; c < NrClusters; c++) begin
         lane_lo = VlWidth'(c * NrLanes);
         tail    = (vl_rem > lane_lo) ? (vl_rem - lane_lo) : '0;
         if (tail > LanesVl) begin
            tail = LanesVl;
         end
         slice_d[c].vl   = vl_rounds + tail;
         slice_d[c].addr = req_addr_i + (AddrWidth'(c * NrLanes) << req_vsew_i);
         pend_d[c]       = (vl_rounds + tail) != '0;
      end
   end

   // ---------------------------------------------------------------------
   // Handshakes and completion bookkeeping.
   // A done only counts once its cluster's command has been taken, either
   // earlier or on the very same edge (issued_n includes this cycle's fire).
   // ---------------------------------------------------------------------
   always_comb begin
      req_fire   = req_valid_i & req_ready_q;
      cl_valid   = (state_q == ISSUE) ? (pend_q & ~issued_q) : '0;
      issue_fire = cl_valid & cl_ready_i;
      issued_n   = issued_q | issue_fire;
      done_acc   = '0;
      if (state_q == ISSUE || state_q == WAIT) begin
         done_acc = cl_done_i & pend_q & issued_n & ~done_q;
      end
      done_n = done_q | done_acc;
      err_n  = err_q | (|(done_acc & cl_err_i));
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. ISSUE may skip WAIT when the final issue and the
   // final done coincide.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_fire) begin
               state_d = (req_vl_i == '0) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            if ((issued_n & pend_q) == pend_q) begin
               state_d = (&done_n) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (&done_n) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers. req_ready is its own flop so that it reads low
   // for the whole time reset is held and rises on the first clean edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_ready_q <= 1'b0;
         slice_q     <= '0;
         store_q     <= 1'b0;
         vsew_q      <= '0;
         pend_q      <= '0;
         issued_q    <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         req_ready_q <= (state_d == IDLE);
         if (req_fire) begin
            slice_q  <= slice_d;
            store_q  <= req_store_i;
            vsew_q   <= req_vsew_i;
            pend_q   <= pend_d;
            done_q   <= ~pend_d;
            issued_q <= '0;
            err_q    <= 1'b0;
         end else begin
            issued_q <= issued_n;
            done_q   <= done_n;
            err_q    <= err_n;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output decode (registers only)
   // ---------------------------------------------------------------------
   always_comb begin
      req_ready_o  = req_ready_q;
      cl_valid_o   = cl_valid;
      resp_valid_o = (state_q == RESP);
      resp_err_o   = (state_q == RESP) & err_q;
      cl_store_o   = {NrClusters{store_q}};
      cl_vsew_o    = {NrClusters{vsew_q}};
      cl_addr_o    = '0;
      cl_vl_o      = '0;
      for (int unsigned c = 0; c < NrClusters; c++) begin
         cl_addr_o[c*AddrWidth +: AddrWidth] = slice_q[c].addr;
         cl_vl_o[c*VlWidth +: VlWidth]       = slice_q[c].vl;
      end
   end

endmodule

// File: tb/tb_cluster_ldst_scheduler.sv
// Purpose : directed table-driven bench for cluster_ldst_scheduler (4 lanes x 4 clusters)
//           plus hand-written sequences for vl=0, staggered issue, chained
//           issue/done, response stall and mid-operation reset.
// Timing  : inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_cluster_ldst_scheduler;

   localparam int unsigned NL = 4;
   localparam int unsigned NC = 4;
   localparam int unsigned AW = 64;
   localparam int unsigned VW = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_store;
   logic [AW-1:0]     req_addr;
   logic [VW-1:0]     req_vl;
   logic [1:0]        req_vsew;
   logic [NC-1:0]     cl_valid, cl_ready, cl_store, cl_done, cl_err;
   logic [NC*AW-1:0]  cl_addr;
   logic [NC*VW-1:0]  cl_vl;
   logic [NC*2-1:0]   cl_vsew;
   logic              resp_valid, resp_ready, resp_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cluster_ldst_scheduler #(
      .NrLanes   (NL),
      .NrClusters(NC),
      .AddrWidth (AW),
      .VlWidth   (VW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_store_i (req_store),
      .req_addr_i  (req_addr),
      .req_vl_i    (req_vl),
      .req_vsew_i  (req_vsew),
      .cl_valid_o  (cl_valid),
      .cl_ready_i  (cl_ready),
      .cl_store_o  (cl_store),
      .cl_addr_o   (cl_addr),
      .cl_vl_o     (cl_vl),
      .cl_vsew_o   (cl_vsew),
      .cl_done_i   (cl_done),
      .cl_err_i    (cl_err),
      .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready),
      .resp_err_o  (resp_err)
   );

   typedef struct packed {
      logic [VW-1:0]          vl;
      logic [1:0]             vsew;
      logic [AW-1:0]          addr;
      logic                   store;
      logic [NC-1:0][VW-1:0]  exp_vl;    // index 0 = cluster 0
      logic [NC-1:0][AW-1:0]  exp_addr;
      logic [NC-1:0]          exp_mask;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [VW-1:0] vl, input logic [1:0] vsew,
                           input logic [AW-1:0] addr, input logic store);
      req_vl    = vl;
      req_vsew  = vsew;
      req_addr  = addr;
      req_store = store;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic finish_resp(input string name);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk({name, "_resp_drop"}, 64'(resp_valid), 64'd0);
      chk({name, "_ready_back"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // c0 first in each packed list is written last ({c3, c2, c1, c0})
      vecs[0] = '{vl: 16'd37, vsew: 2'd2, addr: 64'h1000, store: 1'b0,
                  exp_vl: {16'd8, 16'd8, 16'd9, 16'd12},
                  exp_addr: {64'h1030, 64'h1020, 64'h1010, 64'h1000},
                  exp_mask: 4'b1111};
      vecs[1] = '{vl: 16'd6, vsew: 2'd0, addr: 64'h2000, store: 1'b1,
                  exp_vl: {16'd0, 16'd0, 16'd2, 16'd4},
                  exp_addr: {64'h200C, 64'h2008, 64'h2004, 64'h2000},
                  exp_mask: 4'b0011};
      vecs[2] = '{vl: 16'd64, vsew: 2'd3, addr: 64'h8000, store: 1'b0,
                  exp_vl: {16'd16, 16'd16, 16'd16, 16'd16},
                  exp_addr: {64'h8060, 64'h8040, 64'h8020, 64'h8000},
                  exp_mask: 4'b1111};
      vecs[3] = '{vl: 16'd17, vsew: 2'd1, addr: 64'hFFFF_FFFF_FFFF_FFF0, store: 1'b1,
                  exp_vl: {16'd4, 16'd4, 16'd4, 16'd5},
                  exp_addr: {64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF0},
                  exp_mask: 4'b1111};
      vecs[4] = '{vl: 16'd3, vsew: 2'd2, addr: 64'h100, store: 1'b0,
                  exp_vl: {16'd0, 16'd0, 16'd0, 16'd3},
                  exp_addr: {64'h130, 64'h120, 64'h110, 64'h100},
                  exp_mask: 4'b0001};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_addr   = '0;
      req_vl     = '0;
      req_vsew   = '0;
      cl_ready   = '0;
      cl_done    = '0;
      cl_err     = '0;
      resp_ready = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_cl_valid", 64'(cl_valid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_cl_vl", cl_vl, 64'd0);
      chk("rst_cl_addr0", cl_addr[63:0], 64'd0);
      chk("rst_cl_store", 64'(cl_store), 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 64'(req_ready), 64'd1);

      // ---------------- vl = 0 ----------------
      send_req(16'd0, 2'd2, 64'h3000, 1'b0);
      chk("vl0_cl_valid", 64'(cl_valid), 64'd0);
      chk("vl0_resp_valid", 64'(resp_valid), 64'd1);
      chk("vl0_resp_err", 64'(resp_err), 64'd0);
      chk("vl0_req_ready", 64'(req_ready), 64'd0);
      tick();
      chk("vl0_hold_ready", 64'(req_ready), 64'd0);
      chk("vl0_hold_resp", 64'(resp_valid), 64'd1);
      finish_resp("vl0");

      // ---------------- table-driven split vectors ----------------
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("v%0d_idle_ready", i), 64'(req_ready), 64'd1);
         send_req(vecs[i].vl, vecs[i].vsew, vecs[i].addr, vecs[i].store);
         chk($sformatf("v%0d_valid", i), 64'(cl_valid), 64'(vecs[i].exp_mask));
         chk($sformatf("v%0d_busy", i), 64'(req_ready), 64'd0);
         for (int c = 0; c < NC; c++) begin
            chk($sformatf("v%0d_vl_c%0d", i, c), 64'(cl_vl[c*VW +: VW]), 64'(vecs[i].exp_vl[c]));
            chk($sformatf("v%0d_addr_c%0d", i, c), cl_addr[c*AW +: AW], vecs[i].exp_addr[c]);
         end
         chk($sformatf("v%0d_store", i), 64'(cl_store), 64'({NC{vecs[i].store}}));
         chk($sformatf("v%0d_vsew", i), 64'(cl_vsew), 64'({NC{vecs[i].vsew}}));
         cl_ready = '1;
         tick();
         cl_ready = '0;
         chk($sformatf("v%0d_valid_drop", i), 64'(cl_valid), 64'd0);
         // done+err on clusters that were never given work must be ignored
         cl_done = ~vecs[i].exp_mask;
         cl_err  = ~vecs[i].exp_mask;
         tick();
         cl_done = '0;
         cl_err  = '0;
         chk($sformatf("v%0d_no_resp_yet", i), 64'(resp_valid), 64'd0);
         tick();
         cl_done = vecs[i].exp_mask;
         tick();
         cl_done = '0;
         chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'd1);
         chk($sformatf("v%0d_resp_err", i), 64'(resp_err), 64'd0);
         finish_resp($sformatf("v%0d", i));
      end

      // ---------------- last issue and last done in the same cycle ----------------
      send_req(16'd3, 2'd0, 64'h500, 1'b1);
      chk("chain_valid", 64'(cl_valid), 64'd1);
      cl_ready = 4'b0001;
      cl_done  = 4'b0001;
      cl_err   = 4'b0001;
      tick();
      cl_ready = '0;
      cl_done  = '0;
      cl_err   = '0;
      chk("chain_resp_valid", 64'(resp_valid), 64'd1);
      chk("chain_resp_err", 64'(resp_err), 64'd1);
      finish_resp("chain");

      // ---------------- staggered readies, vl = 64 ----------------
      send_req(16'd64, 2'd2, 64'h4000, 1'b0);
      chk("stag_valid0", 64'(cl_valid), 64'hF);
      cl_ready = 4'b1000;               // c3 first
      cl_done  = 4'b0001;               // spurious: c0 not yet issued
      tick();
      chk("stag_valid1", 64'(cl_valid), 64'h7);
      cl_ready = 4'b0100;               // c2 ready with its done in the same cycle
      cl_done  = 4'b1100;
      tick();
      chk("stag_valid2", 64'(cl_valid), 64'h3);
      cl_ready = 4'b0010;
      cl_done  = '0;
      tick();
      cl_ready = '0;
      chk("stag_valid3", 64'(cl_valid), 64'h1);
      tick();
      chk("stag_hold4", 64'(cl_valid), 64'h1);
      tick();
      chk("stag_hold5", 64'(cl_valid), 64'h1);
      cl_ready = 4'b0001;               // c0 five cycles after c3
      tick();
      cl_ready = '0;
      chk("stag_valid6", 64'(cl_valid), 64'h0);
      chk("stag_no_resp6", 64'(resp_valid), 64'd0);
      cl_done = 4'b0010;
      cl_err  = 4'b0010;
      tick();
      cl_done = '0;
      cl_err  = '0;
      chk("stag_c0_pending", 64'(resp_valid), 64'd0);
      cl_done = 4'b0001;
      tick();
      cl_done = '0;
      chk("stag_resp_valid", 64'(resp_valid), 64'd1);
      chk("stag_resp_err", 64'(resp_err), 64'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stall%0d_valid", k), 64'(resp_valid), 64'd1);
         chk($sformatf("stall%0d_err", k), 64'(resp_err), 64'd1);
         chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'd0);
      end
      finish_resp("stag");

      // ---------------- reset in the middle of ISSUE ----------------
      send_req(16'd37, 2'd2, 64'h1000, 1'b0);
      chk("mrst_valid_pre", 64'(cl_valid), 64'hF);
      rst      = 1'b1;
      cl_ready = 4'b0001;
      tick();
      cl_ready = '0;
      chk("mrst_valid", 64'(cl_valid), 64'd0);
      chk("mrst_req_ready", 64'(req_ready), 64'd0);
      chk("mrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("mrst_cl_vl", cl_vl, 64'd0);
      cl_done = '1;
      cl_err  = '1;
      tick();
      cl_done = '0;
      cl_err  = '0;
      rst     = 1'b0;
      chk("mrst_held_ready", 64'(req_ready), 64'd0);
      tick();
      chk("mrst_release_ready", 64'(req_ready), 64'd1);
      chk("mrst_release_resp", 64'(resp_valid), 64'd0);
      chk("mrst_release_err", 64'(resp_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
